sort_unit_stream: RTL and testbench

//  Streaming insertion sorter: accepts a batch of up to p_depth unsigned words over a val/rdy

---
 rtl/sort_unit_stream.sv | 139 +++++++++++++
 tb/tb_sort_unit_stream.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sort_unit_stream.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sort_unit_stream : streaming insertion sorter, val/rdy in and out, asc/desc
// Rev 1.0
// ----------------------------------------------------------------------------
module sort_unit_stream #(
  parameter int p_nbits = 32,
  parameter int p_depth = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_val,
  output logic                           in_rdy,
  input  logic [p_nbits-1:0]             in_msg,
  input  logic                           in_last,
  input  logic                           in_desc,
  output logic                           out_val,
  input  logic                           out_rdy,
  output logic [p_nbits-1:0]             out_msg,
  output logic                           out_last,
  output logic [$clog2(p_depth+1)-1:0]   count
);

  localparam int c_CW = $clog2(p_depth+1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_FILL  = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_CW-1:0]    r_count;
  logic               r_desc;
  logic [p_nbits-1:0] r_entry [p_depth];
  logic [p_nbits-1:0] w_ins   [p_depth];
  logic [p_nbits-1:0] w_shift [p_depth];
  logic [p_depth-1:0] w_match;
  logic [c_CW-1:0]    w_k;
  logic               w_in_fire;
  logic               w_out_fire;

  assign w_in_fire  = in_val && in_rdy;
  assign w_out_fire = out_val && out_rdy;
  assign count      = r_count;

  // An entry precedes the new element if it sorts before it or ties with it,
  // so equal keys keep their arrival order.
  for (genvar gi = 0; gi < p_depth; gi++) begin : g_match
    assign w_match[gi] = (c_CW'(gi) < r_count) &&
                         (r_desc ? (r_entry[gi] >= in_msg) : (r_entry[gi] <= in_msg));
  end

  always_comb begin
    w_k = '0;
    for (int i = 0; i < p_depth; i++) begin
      w_k = w_k + c_CW'(w_match[i]);
    end
  end

  for (genvar gi = 0; gi < p_depth; gi++) begin : g_ins
    if (gi == 0) begin : g_first
      assign w_ins[gi] = (w_k == '0) ? in_msg : r_entry[0];
    end else begin : g_rest
      assign w_ins[gi] = (c_CW'(gi) < w_k)  ? r_entry[gi] :
                         (c_CW'(gi) == w_k) ? in_msg      : r_entry[gi-1];
    end
  end

  for (genvar gi = 0; gi < p_depth; gi++) begin : g_shift
    if (gi == p_depth - 1) begin : g_top
      assign w_shift[gi] = '0;
    end else begin : g_low
      assign w_shift[gi] = r_entry[gi+1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_in_fire) begin
          w_state_nxt = (in_last || p_depth == 1) ? c_DRAIN : c_FILL;
        end
      end
      c_FILL: begin
        if (w_in_fire && (in_last || r_count == c_CW'(p_depth - 1))) begin
          w_state_nxt = c_DRAIN;
        end
      end
      c_DRAIN: begin
        if (w_out_fire && r_count == c_CW'(1)) begin
          w_state_nxt = c_IDLE;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // reset gates in_rdy so nothing is offered while the block is held in reset
  always_comb begin
    in_rdy   = reset && (r_state == c_IDLE || r_state == c_FILL);
    out_val  = (r_state == c_DRAIN);
    out_msg  = (r_state == c_DRAIN) ? r_entry[0] : '0;
    out_last = (r_state == c_DRAIN) && (r_count == c_CW'(1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_desc  <= 1'b0;
      for (int i = 0; i < p_depth; i++) begin
        r_entry[i] <= '0;
      end
    end else if (w_in_fire) begin
      r_count <= r_count + c_CW'(1);
      if (r_state == c_IDLE) begin
        r_desc <= in_desc;
      end
      for (int i = 0; i < p_depth; i++) begin
        r_entry[i] <= w_ins[i];
      end
    end else if (w_out_fire) begin
      r_count <= r_count - c_CW'(1);
      for (int i = 0; i < p_depth; i++) begin
        r_entry[i] <= w_shift[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sort_unit_stream.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sort_unit_stream : directed table, corner sequences and random batches
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_sort_unit_stream;

  typedef logic [31:0] wq_t [$];

  typedef struct {
    int          n;
    logic [31:0] din  [4];
    bit          desc;
    bit          last;
    int          stall;
    logic [31:0] dexp [4];
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_val, in_rdy, in_last, in_desc;
  logic [31:0] in_msg;
  logic        out_val, out_rdy, out_last;
  logic [31:0] out_msg;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  sort_unit_stream #(.p_nbits(32), .p_depth(4)) dut (
    .clk(clk), .reset(reset),
    .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg), .in_last(in_last), .in_desc(in_desc),
    .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .out_last(out_last),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stable reference: repeatedly take the earliest best-ranked remaining element.
  function automatic wq_t ref_sort(input wq_t v, input bit desc);
    wq_t r;
    while (v.size() > 0) begin
      int b = 0;
      for (int i = 1; i < v.size(); i++) begin
        if (desc ? (v[i] > v[b]) : (v[i] < v[b])) b = i;
      end
      r.push_back(v[b]);
      v.delete(b);
    end
    return r;
  endfunction

  task automatic send(input wq_t v, input bit desc, input bit use_last);
    for (int i = 0; i < v.size(); i++) begin
      int w = 0;
      in_val  = 1'b1;
      in_msg  = v[i];
      in_last = (i == v.size() - 1) && use_last;
      in_desc = (i == 0) ? desc : 1'($urandom);
      @(negedge clk);
      while (!in_rdy && w < 50) begin
        @(posedge clk); #1;
        @(negedge clk);
        w++;
      end
      chk("accept_timeout", (w >= 50), 0);
      chk("out_val_at_accept", out_val, 0);
      chk("count_at_accept", count, i);
      @(posedge clk); #1;
    end
    in_val  = 1'b0;
    in_last = 1'b0;
    chk("first_out_latency", out_val, 1);
  endtask

  task automatic drain(input wq_t exp, input int stall_pct, input string tag);
    int          got = 0;
    int          cyc = 0;
    bit          done = 0;
    bit          stalled = 0;
    logic [31:0] held = '0;
    logic        held_last = 1'b0;
    while (!done && cyc < 200) begin
      out_rdy = ($urandom_range(99) >= stall_pct);
      @(negedge clk);
      if (out_val) begin
        if (stalled) begin
          chk("stall_msg_stable", out_msg, held);
          chk("stall_last_stable", out_last, held_last);
        end
        chk("in_rdy_in_drain", in_rdy, 0);
        chk("count_in_drain", count, exp.size() - got);
        if (out_rdy) begin
          if (got < exp.size()) begin
            chk({tag, "_msg"}, out_msg, exp[got]);
            chk({tag, "_last"}, out_last, (got == exp.size() - 1));
          end else begin
            chk({tag, "_extra_output"}, 1, 0);
          end
          got++;
          stalled = 0;
          if (out_last || got > exp.size()) done = 1;
        end else begin
          stalled   = 1;
          held      = out_msg;
          held_last = out_last;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_rdy = 1'b0;
    chk({tag, "_n_outputs"}, got, exp.size());
    chk({tag, "_count_after"}, count, 0);
  endtask

  vec_t tbl [5];

  initial begin
    wq_t qi, qe, qa, qb;

    reset = 1'b0; in_val = 1'b0; in_msg = '0; in_last = 1'b0; in_desc = 1'b0; out_rdy = 1'b0;

    tbl[0] = '{n:4, din:'{7, 3, 9, 1}, desc:0, last:0, stall:0, dexp:'{1, 3, 7, 9}};
    tbl[1] = '{n:2, din:'{5, 8, 0, 0}, desc:1, last:1, stall:0, dexp:'{8, 5, 0, 0}};
    tbl[2] = '{n:4, din:'{32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0}, desc:0, last:1, stall:0,
               dexp:'{0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF}};
    tbl[3] = '{n:1, din:'{42, 0, 0, 0}, desc:0, last:1, stall:0, dexp:'{42, 0, 0, 0}};
    tbl[4] = '{n:4, din:'{4, 2, 6, 1}, desc:0, last:1, stall:50, dexp:'{1, 2, 4, 6}};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_out_val", out_val, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_msg", out_msg, 0);
    chk("rst_count", count, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_rdy", in_rdy, 1);

    for (int t = 0; t < 5; t++) begin
      qi.delete(); qe.delete();
      for (int j = 0; j < tbl[t].n; j++) begin
        qi.push_back(tbl[t].din[j]);
        qe.push_back(tbl[t].dexp[j]);
      end
      send(qi, tbl[t].desc, tbl[t].last);
      drain(qe, tbl[t].stall, $sformatf("vec%0d", t));
    end

    // back-to-back: second batch waits with in_val high through the first drain
    qa = '{3, 1, 2, 0};
    qb = '{3, 1, 2, 0};
    fork
      begin send(qa, 1'b0, 1'b1); send(qb, 1'b1, 1'b1); end
      begin drain('{0, 1, 2, 3}, 0, "b2b_asc"); drain('{3, 2, 1, 0}, 0, "b2b_desc"); end
    join

    // asynchronous reset in the middle of a fill
    in_val = 1'b1; in_msg = 9; in_last = 1'b0; in_desc = 1'b0;
    @(posedge clk); #1;
    in_msg = 5;
    @(posedge clk); #1;
    in_val = 1'b0;
    chk("count_before_rst", count, 2);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_out_val", out_val, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_in_rdy", in_rdy, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    send('{2, 1}, 1'b0, 1'b1);
    drain('{1, 2}, 0, "after_rst");

    // random batches against the reference model
    for (int b = 0; b < 30; b++) begin
      int  n    = $urandom_range(1, 4);
      bit  desc = 1'($urandom);
      bit  lst  = (n < 4) ? 1'b1 : 1'($urandom);
      qi.delete();
      for (int j = 0; j < n; j++) begin
        qi.push_back(($urandom_range(1) == 0) ? 32'($urandom_range(7)) : $urandom);
      end
      qe = ref_sort(qi, desc);
      send(qi, desc, lst);
      drain(qe, 30, $sformatf("rand%0d", b));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
